// File: rtl/chan_pkg.sv
// Shared types and helpers for the burst error channel: mode/FSM encodings,
// saturating arithmetic and default Galois LFSR tap masks.
package chan_pkg;

    typedef enum logic [1:0] {
        CH_OFF    = 2'b00,
        CH_FIXED  = 2'b01,
        CH_RANDOM = 2'b10
    } ch_mode_t;

    typedef enum logic [1:0] {
        SEEK  = 2'b00,
        BURST = 2'b01,
        DONE  = 2'b10
    } ch_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Right-shifting Galois masks for maximal-length sequences.
    function automatic logic [31:0] default_taps(input int width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            32:      return 32'h8020_0003;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/burst_error_channel_lfsr_gen.sv
// Galois LFSR that advances one step whenever step is high.
module lfsr_gen
    import chan_pkg::*;
#(
    parameter int                 LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0]  TAPS   = LFSR_W'(default_taps(LFSR_W))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= SEED;
        end else if (step) begin
            state_reg <= state_reg[0] ? ((state_reg >> 1) ^ TAPS) : (state_reg >> 1);
        end
    end

    assign state = state_reg;

endmodule

// File: rtl/burst_error_channel.sv
// Channel model injecting one error burst per frame of PERIOD symbols.
// Statistics counters exist only when BURST_ERROR_CHANNEL_STATS_EN is defined.
module burst_error_channel
    import chan_pkg::*;
#(
    parameter int                SYM_W        = 2,
    parameter int                PERIOD       = 32,
    parameter int                BURST_MAX    = 4,
    parameter int                INJECT_LIMIT = 256,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] SEED         = 16'hACE1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [1:0]                       cfg_mode,
    input  logic [$clog2(PERIOD)-1:0]        cfg_offset,
    input  logic [$clog2(BURST_MAX+1)-1:0]   cfg_burst_len,
    input  logic [SYM_W-1:0]                 cfg_mask,
    input  logic                             clr_stats,
    input  logic                             in_valid,
    input  logic [SYM_W-1:0]                 in_sym,
    output logic                             out_valid,
    output logic [SYM_W-1:0]                 out_sym,
    output logic [SYM_W-1:0]                 out_err,
    output logic [15:0]                      sym_ct,
    output logic [15:0]                      err_sym_ct,
    output logic [15:0]                      err_bit_ct
);

    localparam int PW = $clog2(PERIOD);
    localparam int LW = $clog2(BURST_MAX + 1);
    localparam int WW = (INJECT_LIMIT > 0) ? $clog2(INJECT_LIMIT + 1) : 1;

    logic [PW-1:0]    pos_reg;
    logic [1:0]       mode_reg;
    logic [SYM_W-1:0] mask_reg;
    logic [LW-1:0]    len_reg;
    logic [PW-1:0]    start_reg;
    logic [LW-1:0]    rem_reg, rem_next;
    logic [WW-1:0]    win_reg;
    ch_state_t        state_reg, state_next;
    logic             out_valid_reg;
    logic [SYM_W-1:0] out_sym_reg, out_err_reg;

    logic [LFSR_W-1:0] lfsr_state;
    logic              unused_lfsr_bits;
    logic              capture;
    logic [LW-1:0]     cap_len;
    logic [PW-1:0]     cap_start_raw, cap_start;
    logic [PW:0]       start_lim;
    logic [1:0]        eff_mode;
    logic [SYM_W-1:0]  eff_mask;
    logic [LW-1:0]     eff_len;
    logic [PW-1:0]     eff_start;
    logic              mode_on, last_win_sym, corrupt;
    logic [SYM_W-1:0]  err_now;

    lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (capture),
        .state (lfsr_state)
    );

    assign unused_lfsr_bits = ^lfsr_state;

    // Frame parameters are sampled at pos 0 and also used for that same symbol.
    assign capture       = in_valid && (pos_reg == '0);
    assign cap_len       = (cfg_burst_len > LW'(BURST_MAX)) ? LW'(BURST_MAX) : cfg_burst_len;
    assign cap_start_raw = (cfg_mode == CH_RANDOM) ? lfsr_state[PW-1:0] : cfg_offset;
    assign start_lim     = (PW+1)'(PERIOD) - (PW+1)'(cap_len);
    assign cap_start     = ({1'b0, cap_start_raw} > start_lim) ? start_lim[PW-1:0] : cap_start_raw;

    assign eff_mode  = capture ? cfg_mode  : mode_reg;
    assign eff_mask  = capture ? cfg_mask  : mask_reg;
    assign eff_len   = capture ? cap_len   : len_reg;
    assign eff_start = capture ? cap_start : start_reg;
    assign mode_on   = (eff_mode == CH_FIXED) || (eff_mode == CH_RANDOM);

    assign last_win_sym = (INJECT_LIMIT != 0) && (win_reg == WW'(INJECT_LIMIT - 1));

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        corrupt    = 1'b0;
        if (in_valid) begin
            case (state_reg)
                SEEK: begin
                    if (mode_on && (eff_len != '0) && (pos_reg == eff_start)) begin
                        corrupt = 1'b1;
                        if (eff_len > LW'(1)) begin
                            state_next = BURST;
                            rem_next   = eff_len - LW'(1);
                        end
                    end
                end
                BURST: begin
                    corrupt  = 1'b1;
                    rem_next = rem_reg - LW'(1);
                    if (rem_reg == LW'(1)) state_next = SEEK;
                end
                default: corrupt = 1'b0;
            endcase
            // The final in-window symbol may still be hit; any burst is cut after it.
            if (last_win_sym) state_next = DONE;
        end
    end

    assign err_now = corrupt ? eff_mask : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_reg       <= '0;
            mode_reg      <= CH_OFF;
            mask_reg      <= '0;
            len_reg       <= '0;
            start_reg     <= '0;
            rem_reg       <= '0;
            win_reg       <= '0;
            state_reg     <= SEEK;
            out_valid_reg <= 1'b0;
            out_sym_reg   <= '0;
            out_err_reg   <= '0;
        end else begin
            out_valid_reg <= in_valid;
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            if (in_valid) begin
                pos_reg     <= pos_reg + PW'(1);
                out_err_reg <= err_now;
                out_sym_reg <= in_sym ^ err_now;
                if ((INJECT_LIMIT != 0) && (state_reg != DONE)) win_reg <= win_reg + WW'(1);
            end
            if (capture) begin
                mode_reg  <= cfg_mode;
                mask_reg  <= cfg_mask;
                len_reg   <= cap_len;
                start_reg <= cap_start;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_sym   = out_sym_reg;
    assign out_err   = out_err_reg;

`ifdef BURST_ERROR_CHANNEL_STATS_EN
    logic [15:0] sym_ct_reg, err_sym_ct_reg, err_bit_ct_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_ct_reg     <= '0;
            err_sym_ct_reg <= '0;
            err_bit_ct_reg <= '0;
        end else if (clr_stats) begin
            sym_ct_reg     <= '0;
            err_sym_ct_reg <= '0;
            err_bit_ct_reg <= '0;
        end else if (in_valid) begin
            sym_ct_reg <= sat_add16(sym_ct_reg, 16'd1);
            if (corrupt) begin
                err_sym_ct_reg <= sat_add16(err_sym_ct_reg, 16'd1);
                err_bit_ct_reg <= sat_add16(err_bit_ct_reg, 16'($countones(err_now)));
            end
        end
    end

    assign sym_ct     = sym_ct_reg;
    assign err_sym_ct = err_sym_ct_reg;
    assign err_bit_ct = err_bit_ct_reg;
`else
    logic unused_clr_stats;
    assign unused_clr_stats = clr_stats;
    assign sym_ct     = '0;
    assign err_sym_ct = '0;
    assign err_bit_ct = '0;
`endif

endmodule

// File: tb/tb_burst_error_channel.sv
// Directed bench for burst_error_channel: one DUT with the default 256-symbol
// window and one with an unlimited window, both driven by the same stimulus.
module tb_burst_error_channel;

`ifdef BURST_ERROR_CHANNEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] cfg_mode;
    logic [4:0] cfg_offset;
    logic [2:0] cfg_burst_len;
    logic [1:0] cfg_mask;
    logic       clr_stats;
    logic       in_valid;
    logic [1:0] in_sym;

    logic        o1_valid, o2_valid;
    logic [1:0]  o1_sym, o1_err, o2_sym, o2_err;
    logic [15:0] o1_sym_ct, o1_err_sym_ct, o1_err_bit_ct;
    logic [15:0] o2_sym_ct, o2_err_sym_ct, o2_err_bit_ct;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    burst_error_channel dut1 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_offset(cfg_offset),
        .cfg_burst_len(cfg_burst_len), .cfg_mask(cfg_mask), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_sym(in_sym), .out_valid(o1_valid), .out_sym(o1_sym),
        .out_err(o1_err), .sym_ct(o1_sym_ct), .err_sym_ct(o1_err_sym_ct), .err_bit_ct(o1_err_bit_ct)
    );

    burst_error_channel #(.INJECT_LIMIT(0)) dut2 (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_offset(cfg_offset),
        .cfg_burst_len(cfg_burst_len), .cfg_mask(cfg_mask), .clr_stats(clr_stats),
        .in_valid(in_valid), .in_sym(in_sym), .out_valid(o2_valid), .out_sym(o2_sym),
        .out_err(o2_err), .sym_ct(o2_sym_ct), .err_sym_ct(o2_err_sym_ct), .err_bit_ct(o2_err_bit_ct)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        @(negedge clk);
        in_valid = v;
        in_sym   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    initial begin
        logic [1:0]  s, e1, e2, prev_err, prev_sym;
        logic [15:0] g;
        int          st;

        rst = 1'b1; cfg_mode = 2'b00; cfg_offset = '0; cfg_burst_len = '0;
        cfg_mask = '0; clr_stats = 1'b0; in_valid = 1'b0; in_sym = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, o1_valid}, 0);
        chk("rst_sym", o1_sym, 0);
        chk("rst_err", o1_err, 0);
        chk("rst_symct", o1_sym_ct, 0);
        chk("rst_valid2", {31'd0, o2_valid}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Off mode: transparent channel.
        cfg_mode = 2'b00; cfg_offset = 5'd5; cfg_burst_len = 3'd2; cfg_mask = 2'b11;
        for (int i = 0; i < 100; i++) begin
            s = 2'($urandom_range(0, 3));
            step(1'b1, s);
            chk("off_valid", {31'd0, o1_valid}, 1);
            chk("off_sym", o1_sym, s);
            chk("off_err", o1_err, 0);
        end
        chk("off_symct", o1_sym_ct, STATS ? 100 : 0);
        chk("off_errct", o1_err_sym_ct, 0);

        // Fixed offset 5, len 2: window limits dut1 to the first 256 symbols.
        do_reset();
        cfg_mode = 2'b01;
        for (int i = 0; i < 300; i++) begin
            s = 2'($urandom_range(0, 3));
            step(1'b1, s);
            e2 = ((i % 32) == 5 || (i % 32) == 6) ? 2'b11 : 2'b00;
            e1 = (i < 256) ? e2 : 2'b00;
            chk($sformatf("fix_err_%0d", i), o1_err, e1);
            chk($sformatf("fix_sym_%0d", i), o1_sym, s ^ e1);
            chk($sformatf("fix_err2_%0d", i), o2_err, e2);
        end
        chk("fix_symct", o1_sym_ct, STATS ? 300 : 0);
        chk("fix_errsym", o1_err_sym_ct, STATS ? 16 : 0);
        chk("fix_errbit", o1_err_bit_ct, STATS ? 32 : 0);
        chk("fix_errsym2", o2_err_sym_ct, STATS ? 20 : 0);
        chk("fix_errbit2", o2_err_bit_ct, STATS ? 40 : 0);

        // Random start, len 4, against a golden LFSR.
        do_reset();
        cfg_mode = 2'b10; cfg_burst_len = 3'd4; cfg_mask = 2'b01;
        g = 16'hACE1;
        for (int f = 0; f < 64; f++) begin
            st = int'(g[4:0]);
            if (st > 28) st = 28;
            g = lfsr_next(g);
            for (int p = 0; p < 32; p++) begin
                step(1'b1, 2'($urandom_range(0, 3)));
                e2 = (p >= st && p < st + 4) ? 2'b01 : 2'b00;
                e1 = (f * 32 + p < 256) ? e2 : 2'b00;
                chk($sformatf("rnd_err2_f%0d_p%0d", f, p), o2_err, e2);
                chk($sformatf("rnd_err_f%0d_p%0d", f, p), o1_err, e1);
            end
        end

        // Gapped input: only accepted symbols advance the frame.
        do_reset();
        cfg_mode = 2'b01; cfg_offset = 5'd3; cfg_burst_len = 3'd2; cfg_mask = 2'b10;
        for (int k = 0; k < 64; k++) begin
            s = 2'($urandom_range(0, 3));
            step(1'b1, s);
            e1 = ((k % 32) == 3 || (k % 32) == 4) ? 2'b10 : 2'b00;
            chk($sformatf("gap_err_%0d", k), o1_err, e1);
            prev_err = e1;
            prev_sym = s ^ e1;
            step(1'b0, 2'($urandom_range(0, 3)));
            chk($sformatf("gap_idle_valid_%0d", k), {31'd0, o1_valid}, 0);
            chk($sformatf("gap_idle_err_%0d", k), o1_err, prev_err);
            chk($sformatf("gap_idle_sym_%0d", k), o1_sym, prev_sym);
        end

        // Reset in the middle of a burst, then a random-mode frame from SEED.
        do_reset();
        cfg_mode = 2'b01; cfg_offset = 5'd5; cfg_burst_len = 3'd4; cfg_mask = 2'b11;
        for (int i = 0; i < 7; i++) step(1'b1, 2'b00);
        chk("mid_burst_err", o1_err, 2'b11);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'd0, o1_valid}, 0);
        chk("async_rst_sym", o1_sym, 0);
        chk("async_rst_err", o1_err, 0);
        chk("async_rst_symct", o1_sym_ct, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        cfg_mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            s = 2'($urandom_range(0, 3));
            step(1'b1, s);
            e1 = (i >= 1 && i <= 4) ? 2'b11 : 2'b00;
            chk($sformatf("post_rst_err_%0d", i), o1_err, e1);
            chk($sformatf("post_rst_sym_%0d", i), o1_sym, s ^ e1);
        end

        // Length and start clamping: len 7 -> 4, offset 30 -> 28.
        do_reset();
        cfg_mode = 2'b01; cfg_offset = 5'd30; cfg_burst_len = 3'd7; cfg_mask = 2'b01;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 2'b00);
            e1 = (i >= 28) ? 2'b01 : 2'b00;
            chk($sformatf("clamp_err_%0d", i), o1_err, e1);
        end

        // clr_stats wins over an increment on a corrupting cycle.
        do_reset();
        cfg_mode = 2'b01; cfg_offset = 5'd0; cfg_burst_len = 3'd1; cfg_mask = 2'b11;
        clr_stats = 1'b1;
        step(1'b1, 2'b00);
        clr_stats = 1'b0;
        chk("clr_err", o1_err, 2'b11);
        chk("clr_sym", o1_sym, 2'b11);
        chk("clr_symct", o1_sym_ct, 0);
        chk("clr_errsym", o1_err_sym_ct, 0);
        chk("clr_errbit", o1_err_bit_ct, 0);
        step(1'b1, 2'b00);
        chk("after_clr_symct", o1_sym_ct, STATS ? 1 : 0);
        chk("after_clr_errsym", o1_err_sym_ct, 0);
        chk("after_clr_err", o1_err, 0);

`ifdef BURST_ERROR_CHANNEL_STATS_EN
        do_reset();
        cfg_mode = 2'b00;
        repeat (70000) step(1'b1, 2'b00);
        chk("sat_symct2", o2_sym_ct, 16'hFFFF);
        chk("sat_symct1", o1_sym_ct, 16'hFFFF);
        chk("sat_errsym2", o2_err_sym_ct, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
